// File: rtl/spike_scan_controller_pkg.sv
// Shared constants, state encoding and scroll arithmetic for the spike scan controller.
package spike_scan_controller_pkg;

  localparam int unsigned NUM_SPIKES = 73;
  localparam int unsigned COORD_W    = 11;
  localparam int unsigned HIT_WINDOW = 9;
  localparam int unsigned IDX_W      = $clog2(NUM_SPIKES);

  typedef enum logic [2:0] {
    WAIT_TICK,
    SCAN,
    DRAIN,
    ADVANCE,
    HIT
  } scan_state_e;

  // Scroll accumulates in COORD_W+1 bits and pins at the top of the coordinate range.
  function automatic logic [COORD_W-1:0] sat_add(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    logic [COORD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COORD_W] ? '1 : sum[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/spike_scan_controller_if.sv
// Spike table read port: address out, coordinates back one cycle later.
interface spike_scan_controller_if;
  import spike_scan_controller_pkg::*;

  logic [IDX_W-1:0]   spike_index;
  logic [COORD_W-1:0] spike_x;
  logic [COORD_W-1:0] spike_y;

  modport master (output spike_index, input spike_x, input spike_y);
  modport slave  (input spike_index, output spike_x, output spike_y);

endinterface

// File: rtl/spike_scan_controller_hit_compare.sv
// Combinational spike-vs-square test in screen space; also usable for proximity highlight.
module spike_scan_controller_hit_compare
  import spike_scan_controller_pkg::*;
(
  input  logic [COORD_W-1:0] spike_x,
  input  logic [COORD_W-1:0] spike_y,
  input  logic [COORD_W-1:0] scroll,
  input  logic [COORD_W-1:0] square_x,
  input  logic [COORD_W-1:0] square_y,
  output logic               hit
);

  logic [COORD_W-1:0] rel;
  logic [COORD_W-1:0] lo;
  logic [COORD_W:0]   hi;

  always_comb begin
    rel = spike_x - scroll;
    lo  = (square_x >= COORD_W'(HIT_WINDOW)) ? square_x - COORD_W'(HIT_WINDOW) : '0;
    // Upper bound kept one bit wider so squares near the right edge never wrap.
    hi  = {1'b0, square_x} + (COORD_W+1)'(HIT_WINDOW);
    hit = (rel >= lo) && ({1'b0, rel} <= hi) && (spike_y == square_y);
  end

endmodule

// File: rtl/spike_scan_controller.sv
// Per-frame spike table walk: owns scroll offset, game-over latch and tick overrun flag.
module spike_scan_controller
  import spike_scan_controller_pkg::*;
(
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   frame_tick,
  input  logic                   restart,
  input  logic [COORD_W-1:0]     move_step,
  input  logic [COORD_W-1:0]     square_x,
  input  logic [COORD_W-1:0]     square_y,
  spike_scan_controller_if.master tbl,
  output logic [COORD_W-1:0]     scroll_offset,
  output logic                   is_spike_hit,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   tick_overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPIKES - 1);

  scan_state_e        state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               valid_q, valid_d;
  logic [COORD_W-1:0] scroll_q, scroll_d;
  logic               hit_q, hit_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;
  logic               cmp_hit;
  logic               hit_now;

  spike_scan_controller_hit_compare u_cmp (
    .spike_x  (tbl.spike_x),
    .spike_y  (tbl.spike_y),
    .scroll   (scroll_q),
    .square_x (square_x),
    .square_y (square_y),
    .hit      (cmp_hit)
  );

  // valid_q marks that tbl data corresponds to the address issued last cycle.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    valid_d   = 1'b0;
    scroll_d  = scroll_q;
    hit_d     = hit_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    hit_now   = valid_q && cmp_hit;

    unique case (state_q)
      WAIT_TICK: begin
        if (frame_tick) begin
          state_d = SCAN;
          index_d = '0;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (frame_tick) overrun_d = 1'b1;
        if (hit_now) begin
          state_d = HIT;
          hit_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          valid_d = 1'b1;
          if (index_q == LAST_IDX) state_d = DRAIN;
          else                     index_d = index_q + 1'b1;
        end
      end
      DRAIN: begin
        if (frame_tick) overrun_d = 1'b1;
        if (hit_now) begin
          state_d = HIT;
          hit_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = ADVANCE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ADVANCE: begin
        if (frame_tick) overrun_d = 1'b1;
        scroll_d = sat_add(scroll_q, move_step);
        state_d  = WAIT_TICK;
      end
      HIT: begin
        if (restart) begin
          scroll_d  = '0;
          hit_d     = 1'b0;
          overrun_d = 1'b0;
          state_d   = WAIT_TICK;
        end
      end
      default: state_d = WAIT_TICK;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= WAIT_TICK;
      index_q   <= '0;
      valid_q   <= 1'b0;
      scroll_q  <= '0;
      hit_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
      scroll_q  <= scroll_d;
      hit_q     <= hit_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign tbl.spike_index = index_q;
  assign scroll_offset   = scroll_q;
  assign is_spike_hit    = hit_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;
  assign tick_overrun    = overrun_q;

endmodule

// File: tb/tb_spike_scan_controller.sv
// Directed bench for spike_scan_controller with a per-frame outcome scoreboard.
module tb_spike_scan_controller;

  logic        clock;
  logic        resetn;
  logic        frame_tick;
  logic        restart;
  logic [10:0] move_step;
  logic [10:0] square_x;
  logic [10:0] square_y;
  logic [10:0] scroll_offset;
  logic        is_spike_hit;
  logic        busy;
  logic        frame_done;
  logic        tick_overrun;

  spike_scan_controller_if bus ();

  spike_scan_controller dut (
    .clock         (clock),
    .resetn        (resetn),
    .frame_tick    (frame_tick),
    .restart       (restart),
    .move_step     (move_step),
    .square_x      (square_x),
    .square_y      (square_y),
    .tbl           (bus.master),
    .scroll_offset (scroll_offset),
    .is_spike_hit  (is_spike_hit),
    .busy          (busy),
    .frame_done    (frame_done),
    .tick_overrun  (tick_overrun)
  );

  logic [10:0] tab_x [0:127];
  logic [10:0] tab_y [0:127];

  // Registered-read spike ROM
  always @(posedge clock) begin
    bus.spike_x <= tab_x[bus.spike_index];
    bus.spike_y <= tab_y[bus.spike_index];
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit is_hit;
    int offset;
    int scroll;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_scroll = 0;
  bit   m_ovr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 2047) ? 2047 : v;
  endfunction

  function automatic int first_hit(input int scroll, input int sqx, input int sqy);
    int lo, hi, rel;
    lo = sqx - 9;
    if (lo < 0) lo = 0;
    hi = sqx + 9;
    for (int k = 0; k < 73; k++) begin
      rel = (int'(tab_x[k]) + 2048 - scroll) % 2048;
      if (int'(tab_y[k]) == sqy && rel >= lo && rel <= hi) return k;
    end
    return -1;
  endfunction

  // Called at a negedge; raises frame_tick for one cycle and waits for the frame outcome.
  task automatic do_frame(input string tag, input int inject_at);
    exp_t e;
    int   k, t0;
    bit   seen;
    k = first_hit(m_scroll, int'(square_x), int'(square_y));
    if (k < 0) begin
      e.is_hit = 1'b0;
      e.offset = 75;
      e.scroll = sat(m_scroll + int'(move_step));
    end else begin
      e.is_hit = 1'b1;
      e.offset = 3 + k;
      e.scroll = m_scroll;
    end
    sb.push_back(e);
    if (inject_at != 0) m_ovr = 1'b1;

    frame_tick = 1'b1;
    t0 = cyc;
    @(negedge clock);
    frame_tick = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      frame_tick = (inject_at != 0) && (cyc - t0 == inject_at);
      if (frame_done === 1'b1 || is_spike_hit === 1'b1) seen = 1'b1;
      else @(negedge clock);
    end
    frame_tick = 1'b0;

    e = sb.pop_front();
    check({tag, "_outcome_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, 32'(cyc - t0), 32'(e.offset));
      check({tag, "_frame_done"}, 32'(frame_done), 32'(!e.is_hit));
      check({tag, "_hit"}, 32'(is_spike_hit), 32'(e.is_hit));
      check({tag, "_busy"}, 32'(busy), 32'd0);
      @(negedge clock);
      check({tag, "_scroll"}, 32'(scroll_offset), 32'(e.scroll));
      check({tag, "_overrun"}, 32'(tick_overrun), 32'(m_ovr));
      m_scroll = e.scroll;
    end
  endtask

  task automatic do_restart(input string tag);
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    check({tag, "_hit_cleared"}, 32'(is_spike_hit), 32'd0);
    check({tag, "_scroll_cleared"}, 32'(scroll_offset), 32'd0);
    check({tag, "_overrun_cleared"}, 32'(tick_overrun), 32'd0);
    m_scroll = 0;
    m_ovr    = 1'b0;
  endtask

  int t0;
  int dones;

  initial begin
    resetn     = 1'b0;
    frame_tick = 1'b0;
    restart    = 1'b0;
    move_step  = 11'd4;
    square_x   = 11'd40;
    square_y   = 11'd200;
    for (int k = 0; k < 128; k++) begin
      tab_x[k] = 11'((k * 7) % 2048);
      tab_y[k] = 11'd999;
    end
    repeat (3) @(negedge clock);
    check("rst_index", 32'(bus.spike_index), 32'd0);
    check("rst_scroll", 32'(scroll_offset), 32'd0);
    check("rst_hit", 32'(is_spike_hit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_overrun", 32'(tick_overrun), 32'd0);
    resetn = 1'b1;
    @(negedge clock);

    do_frame("all_miss", 0);
    do_frame("overrun", 20);
    dones = 0;
    repeat (80) begin
      @(negedge clock);
      if (frame_done === 1'b1) dones++;
    end
    check("no_extra_done", 32'(dones), 32'd0);

    // Asynchronous reset in the middle of a scan
    frame_tick = 1'b1;
    t0 = cyc;
    @(negedge clock);
    frame_tick = 1'b0;
    while (cyc - t0 < 30) @(negedge clock);
    check("mid_index", 32'(bus.spike_index), 32'd29);
    check("mid_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("async_index", 32'(bus.spike_index), 32'd0);
    check("async_scroll", 32'(scroll_offset), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_overrun", 32'(tick_overrun), 32'd0);
    check("async_hit", 32'(is_spike_hit), 32'd0);
    m_scroll = 0;
    m_ovr    = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    tab_x[10] = 11'd49;
    tab_y[10] = 11'd200;
    do_frame("hit_49", 0);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    @(negedge clock);
    check("hit_tick_ignored_ovr", 32'(tick_overrun), 32'd0);
    check("hit_tick_ignored_hit", 32'(is_spike_hit), 32'd1);
    check("hit_tick_ignored_busy", 32'(busy), 32'd0);
    do_restart("restart1");

    move_step = 11'd0;
    tab_x[10] = 11'd50;
    do_frame("miss_50", 0);
    tab_x[10] = 11'd31;
    do_frame("hit_31", 0);
    do_restart("restart2");
    tab_x[10] = 11'd30;
    do_frame("miss_30", 0);

    tab_y[10] = 11'd999;
    square_x  = 11'd3;
    tab_x[20] = 11'd0;
    tab_y[20] = 11'd200;
    do_frame("lo_clamp", 0);
    do_restart("restart3");
    tab_y[20] = 11'd999;
    square_x  = 11'd40;

    move_step = 11'd2045;
    do_frame("to_2045", 0);
    move_step = 11'd10;
    do_frame("saturate", 20);
    tab_x[5] = 11'd39;
    tab_y[5] = 11'd200;
    do_frame("wrap_hit", 0);
    do_restart("restart4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_scan_controller.md
# spike_scan_controller

Sequential collision scheduler for the side-scrolling level. Once per screen update it walks the 73-entry spike table through a single shared read port, one entry per cycle, and compares each spike against the player square using the current scroll offset. It owns the scroll offset and the game-over (hit) latch, and returns to idle-wait until the next frame tick. It sits between the frame timer, the spike coordinate ROM and the renderer/game FSM.

## Interface
- NUM_SPIKES, 73, number of spike table entries
- COORD_W, 11, coordinate and scroll width
- HIT_WINDOW, 9, half-width of the horizontal hit window in pixels
- clock  input  1  system clock
- resetn  input  1  asynchronous, active-low reset
- frame_tick  input  1  one-cycle pulse per screen update
- restart  input  1  level restart request (jump button), level-sensitive
- move_step  input  COORD_W  scroll increment applied per frame
- square_x, square_y  input  COORD_W each  player square bottom-left corner
- spike_index  output  7  table read address
- spike_x, spike_y  input  COORD_W each  table read data, valid one cycle after spike_index
- scroll_offset  output  COORD_W  accumulated scroll
- is_spike_hit  output  1  sticky game-over flag
- busy  output  1  scan in progress
- frame_done  output  1  one-cycle pulse at end of a frame's processing
- tick_overrun  output  1  sticky: frame_tick arrived while busy

## Operation
- States: WAIT_TICK, SCAN, DRAIN, ADVANCE, HIT.
- Reset: state WAIT_TICK; spike_index 0, scroll_offset 0, is_spike_hit 0, busy 0, frame_done 0, tick_overrun 0.
- WAIT_TICK: frame_tick -> SCAN, spike_index 0, busy 1.
- SCAN: spike_index increments each cycle; on reaching NUM_SPIKES-1 -> DRAIN. Compare pipeline runs one cycle behind the address.
- DRAIN: final compare; -> ADVANCE if no hit.
- ADVANCE: scroll_offset <= min(scroll_offset + move_step, 2047) (saturating, 12-bit sum); frame_done 1; busy 0; -> WAIT_TICK.
- Compare (per valid data cycle): rel = (spike_x - scroll_offset) mod 2^COORD_W; lo = square_x - HIT_WINDOW clamped at 0; hi = square_x + HIT_WINDOW in COORD_W+1 bits (no wrap); hit if lo <= rel <= hi and spike_y == square_y.
- Any hit: is_spike_hit 1, -> HIT immediately; remaining entries abandoned; scroll not advanced; no frame_done for that frame; busy 0.
- HIT: ignores frame_tick (no overrun flagged); restart -> scroll_offset 0, is_spike_hit 0, tick_overrun 0, -> WAIT_TICK.
- restart in any other state: ignored.
- frame_tick while busy: dropped, tick_overrun set (cleared only by reset or restart from HIT).
- frame_tick coincident with ADVANCE: dropped, tick_overrun set.

## Timing
- frame_tick sampled high in cycle T -> spike_index = k during cycle T+1+k, compare of entry k in cycle T+2+k.
- No hit: last compare T+1+NUM_SPIKES (DRAIN); ADVANCE and frame_done at T+2+NUM_SPIKES (T+75 for 73); new scroll_offset visible T+3+NUM_SPIKES.
- Hit on entry k: is_spike_hit high from T+3+k; busy low same cycle.
- Earliest accepted next tick: T+3+NUM_SPIKES.
- All outputs registered; resetn asserted mid-scan aborts immediately to reset values.

## Structure
- Shared package: state encoding enum, NUM_SPIKES, COORD_W, HIT_WINDOW, spike index width (clog2 of NUM_SPIKES).
- One sub-module natural: spike_hit_compare (combinational window/y compare, rel/lo/hi arithmetic), reused by the renderer's proximity highlight.
- Remainder (FSM, index counter, one-cycle valid pipe, scroll accumulator, flags) in the top module.

## Test plan
- Reset then one tick, table all y=999, square (40,200), move_step 4 -> frame_done at T+75, scroll_offset 4, is_spike_hit 0.
- Entry 10 at (49,200), scroll 0, square (40,200) -> hit at compare cycle T+12, is_spike_hit high T+13, scroll stays 0, no frame_done.
- Entry 10 at (50,200) same setup -> no hit (rel 50 > hi 49); entry at (31,200) hits, (30,200) does not.
- square_x 3, spike rel 0 at same y -> hit (lo clamps to 0); scroll 2045 + move_step 10 -> scroll_offset 2047.
- Second frame_tick at T+20 -> dropped, tick_overrun 1, frame_done still once at T+75.
- In HIT, assert restart -> next cycle is_spike_hit 0, scroll_offset 0, tick_overrun 0; resetn low at T+30 mid-scan -> all outputs reset values asynchronously.
